ahb_dmem_slave: RTL and testbench



---
 rtl/ahb_dmem_slave_if.sv | 30 +++
 rtl/ahb_dmem_slave.sv | 182 ++++++++++++++++++
 tb/tb_ahb_dmem_slave.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_dmem_slave_if.sv
// Bus bundle between the LSU AHB master and the data-memory responder.
interface ahb_dmem_slave_if;
    logic [31:0] haddr_m2h;
    logic        haddr_ctrl_m2h;
    logic        hwrite_m2h;
    logic [31:0] hwdata_m2h;
    logic [31:0] hdata_s2m;
    logic        hresp_s2m;
    logic        hready_s2m;

    modport master (
        output haddr_m2h,
        output haddr_ctrl_m2h,
        output hwrite_m2h,
        output hwdata_m2h,
        input  hdata_s2m,
        input  hresp_s2m,
        input  hready_s2m
    );

    modport slave (
        input  haddr_m2h,
        input  haddr_ctrl_m2h,
        input  hwrite_m2h,
        input  hwdata_m2h,
        output hdata_s2m,
        output hresp_s2m,
        output hready_s2m
    );
endinterface

// File: rtl/ahb_dmem_slave.sv
// AHB-lite data-memory responder with sized, lane-masked access and wait states.
// Define AHB_DMEM_MISALIGN_ERR_EN to raise errors on misaligned half/word access.
module ahb_dmem_slave #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned WAIT_CYC  = 1,
    parameter logic [1:0]  REGION    = 2'b01
) (
    input logic             clk,
    input logic             rstn,
    ahb_dmem_slave_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_RECOVER
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [26:0] r_addr;
    logic [2:0]  r_typ;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic        hready_q;
    logic        hresp_q;
    logic [31:0] hdata_q;

    logic [31:0] mem [MEM_WORDS];

    logic [AW-1:0] widx;
    logic [1:0]    off;
    logic [31:0]   word;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   rdata;
    logic [31:0]   wmask;
    logic [31:0]   wdata_al;
    logic          is_h;
    logic          is_w;
    logic          is_u;
    logic          bad_typ;
    logic          misalign;
    logic          err;
    logic          accept;
    logic          fire;
    logic          we;

    assign accept = bus.haddr_ctrl_m2h
                  && (bus.haddr_m2h[31:30] == REGION);
    assign fire   = (state == S_WAIT) && (cnt == 4'd1);
    assign we     = fire && r_wr && !err;

    assign widx  = AW'(r_addr[26:2] % 25'(MEM_WORDS));
    assign off   = r_addr[1:0];
    assign word  = mem[widx];
    assign rbyte = 8'(word >> {off, 3'b000});
    assign rhalf = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        bad_typ = 1'b1;
        is_h    = 1'b0;
        is_w    = 1'b0;
        is_u    = 1'b0;
        unique case (r_typ)
            3'b000: bad_typ = 1'b0;
            3'b001: begin
                bad_typ = 1'b0;
                is_h    = 1'b1;
            end
            3'b010: begin
                bad_typ = 1'b0;
                is_w    = 1'b1;
            end
            3'b100: begin
                bad_typ = r_wr;
                is_u    = 1'b1;
            end
            3'b101: begin
                bad_typ = r_wr;
                is_h    = 1'b1;
                is_u    = 1'b1;
            end
            default: bad_typ = 1'b1;
        endcase
    end

`ifdef AHB_DMEM_MISALIGN_ERR_EN
    assign misalign = (is_h && off[0])
                    || (is_w && (off != 2'b00));
`else
    // Offsets are aligned down by lane selection below.
    assign misalign = 1'b0;
`endif

    assign err = bad_typ || misalign;

    always_comb begin
        rdata = 32'd0;
        unique case (1'b1)
            is_w: rdata = word;
            is_h: rdata = {{16{!is_u && rhalf[15]}}, rhalf};
            default: rdata = {{24{!is_u && rbyte[7]}}, rbyte};
        endcase
    end

    always_comb begin
        wmask    = 32'd0;
        wdata_al = r_wdata;
        unique case (1'b1)
            is_w: begin
                wmask    = 32'hFFFF_FFFF;
                wdata_al = r_wdata;
            end
            is_h: begin
                wmask    = off[1] ? 32'hFFFF_0000
                                  : 32'h0000_FFFF;
                wdata_al = {2{r_wdata[15:0]}};
            end
            default: begin
                wmask    = 32'h0000_00FF << {off, 3'b000};
                wdata_al = {4{r_wdata[7:0]}};
            end
        endcase
    end

    // Array contents are not reset; write lands on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= (word & ~wmask) | (wdata_al & wmask);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            r_addr   <= 27'd0;
            r_typ    <= 3'd0;
            r_wr     <= 1'b0;
            r_wdata  <= 32'd0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hdata_q  <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        r_addr   <= bus.haddr_m2h[26:0];
                        r_typ    <= bus.haddr_m2h[29:27];
                        r_wr     <= bus.hwrite_m2h;
                        r_wdata  <= bus.hwdata_m2h;
                        cnt      <= 4'(WAIT_CYC);
                        hready_q <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (fire) begin
                        hready_q <= 1'b1;
                        hresp_q  <= err;
                        hdata_q  <= (r_wr || err) ? 32'd0 : rdata;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    hresp_q <= 1'b0;
                    state   <= S_RECOVER;
                end
                S_RECOVER: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    assign bus.hready_s2m = hready_q;
    assign bus.hresp_s2m  = hresp_q;
    assign bus.hdata_s2m  = hdata_q;
endmodule

// File: tb/tb_ahb_dmem_slave.sv
// Scoreboard bench: two responders (1 and 3 wait states) share one stimulus
// stream and are checked against a byte-addressed reference memory.
module tb_ahb_dmem_slave;
    localparam int MW = 1024;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    ahb_dmem_slave_if bus1 ();
    ahb_dmem_slave_if bus3 ();

    assign bus3.haddr_m2h      = bus1.haddr_m2h;
    assign bus3.haddr_ctrl_m2h = bus1.haddr_ctrl_m2h;
    assign bus3.hwrite_m2h     = bus1.hwrite_m2h;
    assign bus3.hwdata_m2h     = bus1.hwdata_m2h;

    ahb_dmem_slave #(
        .MEM_WORDS(MW),
        .WAIT_CYC (1),
        .REGION   (2'b01)
    ) dut1 (
        .clk (clk),
        .rstn(rstn),
        .bus (bus1)
    );

    ahb_dmem_slave #(
        .MEM_WORDS(MW),
        .WAIT_CYC (3),
        .REGION   (2'b01)
    ) dut3 (
        .clk (clk),
        .rstn(rstn),
        .bus (bus3)
    );

    typedef struct {
        bit          chk_data;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  mem_b[int];
    int          lowc[2];
    bit          recov[2];
    logic [31:0] lastd[2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic int bidx(input logic [26:0] a);
        return ((int'(a) >> 2) % MW) * 4;
    endfunction

    function automatic logic [7:0] rdb(input int a);
        if (mem_b.exists(a)) return mem_b[a];
        return 8'hxx;
    endfunction

    // Reference: byte-addressed memory, sizes in bytes, extension by arithmetic.
    task automatic model(input logic [2:0] typ, input bit wr,
                         input logic [26:0] a, input logic [31:0] wd,
                         output exp_t e);
        int     base;
        int     off;
        int     sz;
        bit     legal;
        bit     mis;
        longint v;
        base = bidx(a);
        off  = int'(a[1:0]);
        sz   = (typ[1:0] == 2'd0) ? 1 : (typ[1:0] == 2'd1) ? 2 : 4;
        mis  = 1'b0;
        if (wr) legal = (typ <= 3'd2);
        else    legal = (typ inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef AHB_DMEM_MISALIGN_ERR_EN
        mis = (off % sz) != 0;
`endif
        e.err      = !legal || mis;
        e.chk_data = !wr || e.err;
        e.data     = 32'd0;
        if (e.err) return;
        off = off - (off % sz);
        if (wr) begin
            for (int i = 0; i < sz; i++) mem_b[base + off + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < sz; i++)
                v += longint'(rdb(base + off + i)) << (8 * i);
            if (!typ[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
                v -= longint'(1) << (8 * sz);
            e.data = 32'(v);
        end
    endtask

    task automatic xfer(input logic [1:0] region, input logic [2:0] typ,
                        input bit wr, input logic [26:0] a,
                        input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        bus1.haddr_m2h      = {region, typ, a};
        bus1.haddr_ctrl_m2h = 1'b1;
        bus1.hwrite_m2h     = wr;
        bus1.hwdata_m2h     = wd;
        if (region == 2'b01) begin
            model(typ, wr, a, wd, e);
            q1.push_back(e);
            q3.push_back(e);
        end
        @(negedge clk);
        bus1.haddr_ctrl_m2h = 1'b0;
        bus1.haddr_m2h      = $urandom;
        bus1.hwdata_m2h     = $urandom;
        bus1.hwrite_m2h     = 1'($urandom);
        for (int i = 0; i < 5; i++) begin
            if (region != 2'b01) begin
                chk("oor_ready1", {31'd0, bus1.hready_s2m}, 32'd1);
                chk("oor_ready3", {31'd0, bus3.hready_s2m}, 32'd1);
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready1"}, {31'd0, bus1.hready_s2m}, 32'd1);
        chk({tag, "_resp1"},  {31'd0, bus1.hresp_s2m},  32'd0);
        chk({tag, "_data1"},  bus1.hdata_s2m,           32'd0);
        chk({tag, "_ready3"}, {31'd0, bus3.hready_s2m}, 32'd1);
        chk({tag, "_resp3"},  {31'd0, bus3.hresp_s2m},  32'd0);
        chk({tag, "_data3"},  bus3.hdata_s2m,           32'd0);
    endtask

    task automatic mon(input int id, input logic rdy, input logic rsp,
                       input logic [31:0] dat, input int wc);
        exp_t e;
        bit   got;
        if (!rstn) begin
            lowc[id]  = 0;
            recov[id] = 1'b0;
            return;
        end
        if (recov[id]) begin
            chk($sformatf("dut%0d_recover_ready", id), {31'd0, rdy}, 32'd1);
            chk($sformatf("dut%0d_recover_resp", id), {31'd0, rsp}, 32'd0);
            chk($sformatf("dut%0d_recover_data", id), dat, lastd[id]);
            recov[id] = 1'b0;
        end
        if (!rdy) begin
            lowc[id]++;
        end else if (lowc[id] > 0) begin
            got = (id == 0) ? (q1.size() > 0) : (q3.size() > 0);
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL dut%0d_unexpected_resp: got response expected none",
                         id);
            end else begin
                if (id == 0) e = q1.pop_front();
                else         e = q3.pop_front();
                chk($sformatf("dut%0d_wait_cycles", id), lowc[id], wc);
                chk($sformatf("dut%0d_hresp", id), {31'd0, rsp},
                    {31'd0, e.err});
                if (e.chk_data)
                    chk($sformatf("dut%0d_hdata", id), dat, e.data);
            end
            recov[id] = 1'b1;
            lastd[id] = dat;
            lowc[id]  = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus1.hready_s2m, bus1.hresp_s2m, bus1.hdata_s2m, 1);
        mon(1, bus3.hready_s2m, bus3.hresp_s2m, bus3.hdata_s2m, 3);
    end

    initial begin
        lowc[0]             = 0;
        lowc[1]             = 0;
        recov[0]            = 1'b0;
        recov[1]            = 1'b0;
        bus1.haddr_m2h      = 32'd0;
        bus1.haddr_ctrl_m2h = 1'b0;
        bus1.hwrite_m2h     = 1'b0;
        bus1.hwdata_m2h     = 32'd0;
        rstn                = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("in_reset");
        rstn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk_reset_outs("idle");
        end

        // Word store/load and sized loads on the same word.
        xfer(2'b01, 3'b010, 1'b1, 27'h10, 32'hDEAD_BEEF);
        xfer(2'b01, 3'b010, 1'b0, 27'h10, 32'd0);
        xfer(2'b01, 3'b000, 1'b0, 27'h13, 32'd0);
        xfer(2'b01, 3'b100, 1'b0, 27'h13, 32'd0);
        xfer(2'b01, 3'b001, 1'b0, 27'h12, 32'd0);
        xfer(2'b01, 3'b101, 1'b0, 27'h10, 32'd0);
        xfer(2'b01, 3'b000, 1'b1, 27'h11, 32'h0000_0012);
        xfer(2'b01, 3'b010, 1'b0, 27'h10, 32'd0);
        // Misaligned word load, illegal read code, illegal write code.
        xfer(2'b01, 3'b010, 1'b0, 27'h12, 32'd0);
        xfer(2'b01, 3'b111, 1'b0, 27'h10, 32'd0);
        xfer(2'b01, 3'b100, 1'b1, 27'h10, 32'hFFFF_FFFF);
        xfer(2'b01, 3'b010, 1'b0, 27'h10, 32'd0);

        // Reset during WAIT of a store drops the store.
        xfer(2'b01, 3'b010, 1'b1, 27'h20, 32'h1111_1111);
        @(negedge clk);
        bus1.haddr_m2h      = {2'b01, 3'b010, 27'h20};
        bus1.haddr_ctrl_m2h = 1'b1;
        bus1.hwrite_m2h     = 1'b1;
        bus1.hwdata_m2h     = 32'h2222_2222;
        @(negedge clk);
        bus1.haddr_ctrl_m2h = 1'b0;
        rstn                = 1'b0;
        #1;
        chk_reset_outs("mid_reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        xfer(2'b01, 3'b010, 1'b0, 27'h20, 32'd0);

        // Out-of-region traffic is ignored, including stores.
        xfer(2'b10, 3'b010, 1'b1, 27'h10, 32'h5555_5555);
        xfer(2'b00, 3'b010, 1'b0, 27'h10, 32'd0);
        xfer(2'b01, 3'b010, 1'b0, 27'h10, 32'd0);

        // Random traffic over eight initialised words, with aliased upper bits.
        for (int k = 0; k < 8; k++)
            xfer(2'b01, 3'b010, 1'b1, 27'(32'h100 + 4 * k), $urandom);
        for (int n = 0; n < 150; n++) begin
            logic [26:0] a;
            a = 27'(($urandom_range(0, 15) << 12)
                  | (32'h100 + 4 * $urandom_range(0, 7))
                  | $urandom_range(0, 3));
            xfer(2'b01, 3'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                           : ($urandom_range(0, 1) ? $urandom_range(0, 2)
                                                   : $urandom_range(4, 5))),
                 1'($urandom_range(0, 1)), a, $urandom);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard1_drained", q1.size(), 32'd0);
        chk("scoreboard3_drained", q3.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
